apb_regbank_slave: RTL and testbench

- APB3 completer (slave) sitting on the APB side of the AHB-to-APB bridge; it is the responder to the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA requests.
- Provides a small memory-mapped register bank (ID, control, scratch, W1C status, transfer counter, GPIO) with programmable wait states (PREADY) and error response (PSLVERR).
- Runs on the bridge clock, qualified by PCLKEN.

---
 rtl/apb_regbank_pkg.sv | 37 +++
 rtl/apb_regbank_if.sv | 24 ++
 rtl/apb_regbank_regs.sv | 110 +++++++++++
 rtl/apb_regbank_slave.sv | 94 +++++++++
 tb/tb_apb_regbank_slave.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/apb_regbank_pkg.sv
// Shared constants for the APB register bank: register offsets, CTRL/STATUS
// bit positions and the completer FSM state encoding.
package apb_regbank_pkg;

  localparam int NUM_REGS = 8;

  // Byte offsets within the 32-byte register window
  localparam logic [4:0] ADDR_ID       = 5'h00;
  localparam logic [4:0] ADDR_CTRL     = 5'h04;
  localparam logic [4:0] ADDR_SCRATCH0 = 5'h08;
  localparam logic [4:0] ADDR_SCRATCH1 = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h10;
  localparam logic [4:0] ADDR_COUNT    = 5'h14;
  localparam logic [4:0] ADDR_GPIO_OUT = 5'h18;
  localparam logic [4:0] ADDR_GPIO_IN  = 5'h1C;

  localparam int CTRL_WAIT_LSB = 0;
  localparam int CTRL_WAIT_MSB = 3;
  localparam int CTRL_ERR_EN   = 8;
  localparam int CTRL_IRQ_EN   = 9;
  localparam logic [31:0] CTRL_MASK = 32'h0000_030F;

  localparam int STAT_UNMAPPED = 0;
  localparam int STAT_ABORT    = 1;
  localparam int STAT_RO_WRITE = 2;
  localparam int STAT_BITS     = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apbState_t;

  function automatic logic isReadOnly(input logic [4:0] off);
    return (off == ADDR_ID) || (off == ADDR_COUNT) || (off == ADDR_GPIO_IN);
  endfunction

endpackage

// File: rtl/apb_regbank_if.sv
// APB3 bus bundle between the bridge (master) and the register bank (slave).
interface apb_regbank_if #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
);
  logic                 PSEL;
  logic                 PENABLE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic                 PWRITE;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_regbank_regs.sv
// Register storage for the APB bank: CTRL, scratch, W1C STATUS, COUNT, GPIO,
// the read mux and error decode. Writes happen only on the commit strobe.
module apb_regbank_regs
  import apb_regbank_pkg::*;
#(
  parameter int                    ADDRWIDTH = 16,
  parameter int                    DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0]  ID_VALUE  = 32'hA5B0_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clkEn,
  input  logic                 i_commit,
  input  logic                 i_abortSet,
  input  logic                 i_write,
  input  logic [ADDRWIDTH-3:0] i_wordAddr,
  input  logic [DATAWIDTH-1:0] i_wdata,
  input  logic [DATAWIDTH-1:0] i_gpioIn,
  output logic [DATAWIDTH-1:0] o_rdata,
  output logic                 o_err,
  output logic [3:0]           o_wait,
  output logic                 o_errEn,
  output logic [DATAWIDTH-1:0] o_gpioOut,
  output logic                 o_irq
);

  logic [DATAWIDTH-1:0] r_ctrl;
  logic [DATAWIDTH-1:0] r_scratch0;
  logic [DATAWIDTH-1:0] r_scratch1;
  logic [STAT_BITS-1:0] r_status;
  logic [15:0]          r_count;
  logic [DATAWIDTH-1:0] r_gpioOut;
  logic [DATAWIDTH-1:0] r_gpioIn;
  logic                 r_irq;

  logic                 w_mapped;
  logic [4:0]           w_off;
  logic                 w_roTarget;
  logic                 w_okWrite;
  logic [STAT_BITS-1:0] w_statusSet;
  logic [STAT_BITS-1:0] w_statusClr;
  logic [STAT_BITS-1:0] w_statusNext;

  assign w_mapped   = ((i_wordAddr >> 3) == '0);
  assign w_off      = {i_wordAddr[2:0], 2'b00};
  assign w_roTarget = isReadOnly(w_off);
  assign o_err      = !w_mapped || (i_write && w_roTarget);
  assign w_okWrite  = i_commit && i_write && w_mapped && !w_roTarget;

  // Hardware set is OR'ed in after the W1C clear so a coincident set wins
  always_comb begin
    w_statusSet = '0;
    w_statusClr = '0;
    if (i_commit && !w_mapped)                         w_statusSet[STAT_UNMAPPED] = 1'b1;
    if (i_commit && i_write && w_mapped && w_roTarget) w_statusSet[STAT_RO_WRITE] = 1'b1;
    if (i_abortSet)                                    w_statusSet[STAT_ABORT]    = 1'b1;
    if (w_okWrite && (w_off == ADDR_STATUS))           w_statusClr = i_wdata[STAT_BITS-1:0];
    w_statusNext = (r_status & ~w_statusClr) | w_statusSet;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_status   <= '0;
      r_count    <= '0;
      r_gpioOut  <= '0;
      r_gpioIn   <= '0;
      r_irq      <= 1'b0;
    end else if (i_clkEn) begin
      r_gpioIn <= i_gpioIn;
      r_status <= w_statusNext;
      r_irq    <= (|r_status) && r_ctrl[CTRL_IRQ_EN];
      if (w_okWrite) begin
        case (w_off)
          ADDR_CTRL:     r_ctrl     <= i_wdata & CTRL_MASK[DATAWIDTH-1:0];
          ADDR_SCRATCH0: r_scratch0 <= i_wdata;
          ADDR_SCRATCH1: r_scratch1 <= i_wdata;
          ADDR_GPIO_OUT: r_gpioOut  <= i_wdata;
          default: ;
        endcase
      end
      if (i_commit && !o_err) r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (w_mapped) begin
      case (w_off)
        ADDR_ID:       o_rdata = ID_VALUE;
        ADDR_CTRL:     o_rdata = r_ctrl;
        ADDR_SCRATCH0: o_rdata = r_scratch0;
        ADDR_SCRATCH1: o_rdata = r_scratch1;
        ADDR_STATUS:   o_rdata = {{(DATAWIDTH-STAT_BITS){1'b0}}, r_status};
        ADDR_COUNT:    o_rdata = {{(DATAWIDTH-16){1'b0}}, r_count};
        ADDR_GPIO_OUT: o_rdata = r_gpioOut;
        ADDR_GPIO_IN:  o_rdata = r_gpioIn;
        default:       o_rdata = '0;
      endcase
    end
  end

  assign o_wait    = r_ctrl[CTRL_WAIT_MSB:CTRL_WAIT_LSB];
  assign o_errEn   = r_ctrl[CTRL_ERR_EN];
  assign o_gpioOut = r_gpioOut;
  assign o_irq     = r_irq;

endmodule

// File: rtl/apb_regbank_slave.sv
// APB3 completer: IDLE/ACCESS FSM with programmable wait states, driving the
// register bank through a commit strobe; everything advances on PCLKEN edges.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int                   ADDRWIDTH = 16,
  parameter int                   DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] ID_VALUE  = 32'hA5B0_0001
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  apb_regbank_if.slave         apb,
  input  logic [DATAWIDTH-1:0] GPIO_IN,
  output logic [DATAWIDTH-1:0] GPIO_OUT,
  output logic                 IRQ
);

  apbState_t            r_state;
  logic [ADDRWIDTH-3:0] r_wordAddr;
  logic                 r_write;
  logic [3:0]           r_waitCnt;

  logic                 w_ready;
  logic                 w_commit;
  logic                 w_abortSet;
  logic [DATAWIDTH-1:0] w_rdata;
  logic                 w_err;
  logic [3:0]           w_wait;
  logic                 w_errEn;
  logic                 w_unused;

  assign w_unused   = &{1'b0, apb.PADDR[1:0]};
  assign w_ready    = (r_state == ST_ACCESS) && (r_waitCnt == 4'd0);
  assign w_commit   = PCLKEN && w_ready && apb.PSEL;
  assign w_abortSet = PCLKEN && (((r_state == ST_IDLE) && apb.PSEL && apb.PENABLE) ||
                                 ((r_state == ST_ACCESS) && !apb.PSEL));

  // A dropped PSEL in ACCESS aborts regardless of the remaining wait count
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= ST_IDLE;
      r_wordAddr <= '0;
      r_write    <= 1'b0;
      r_waitCnt  <= '0;
    end else if (PCLKEN) begin
      case (r_state)
        ST_IDLE: begin
          if (apb.PSEL && !apb.PENABLE) begin
            r_wordAddr <= apb.PADDR[ADDRWIDTH-1:2];
            r_write    <= apb.PWRITE;
            r_waitCnt  <= w_wait;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!apb.PSEL || (r_waitCnt == 4'd0)) begin
            r_state <= ST_IDLE;
          end else if (apb.PENABLE) begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  apb_regbank_regs #(
    .ADDRWIDTH (ADDRWIDTH),
    .DATAWIDTH (DATAWIDTH),
    .ID_VALUE  (ID_VALUE)
  ) u_regs (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .i_clkEn    (PCLKEN),
    .i_commit   (w_commit),
    .i_abortSet (w_abortSet),
    .i_write    (r_write),
    .i_wordAddr (r_wordAddr),
    .i_wdata    (apb.PWDATA),
    .i_gpioIn   (GPIO_IN),
    .o_rdata    (w_rdata),
    .o_err      (w_err),
    .o_wait     (w_wait),
    .o_errEn    (w_errEn),
    .o_gpioOut  (GPIO_OUT),
    .o_irq      (IRQ)
  );

  assign apb.PREADY  = w_ready;
  assign apb.PRDATA  = (w_ready && !r_write) ? w_rdata : '0;
  assign apb.PSLVERR = w_ready && w_errEn && w_err;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave: hand-computed expectations checked
// with immediate assertions after each APB transfer.
module tb_apb_regbank_slave;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PCLKEN  = 1'b1;
  logic [31:0] GPIO_IN = '0;
  logic [31:0] GPIO_OUT;
  logic        IRQ;

  bit gateMode = 1'b0;
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  logic [31:0] rd;
  logic        se;
  int          wt;

  apb_regbank_if #(.ADDRWIDTH(16), .DATAWIDTH(32)) apbBus ();

  apb_regbank_slave #(
    .ADDRWIDTH (16),
    .DATAWIDTH (32),
    .ID_VALUE  (32'hA5B0_0001)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .PCLKEN   (PCLKEN),
    .apb      (apbBus),
    .GPIO_IN  (GPIO_IN),
    .GPIO_OUT (GPIO_OUT),
    .IRQ      (IRQ)
  );

  always #5 HCLK = ~HCLK;

  // Gated mode gives one PCLKEN edge in every four HCLK edges
  always @(negedge HCLK) begin
    cyc++;
    PCLKEN = gateMode ? ((cyc % 4) == 0) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    do @(posedge HCLK); while (PCLKEN !== 1'b1);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic slverr, output int waits);
    apbBus.PSEL    = 1'b1;
    apbBus.PENABLE = 1'b0;
    apbBus.PADDR   = addr;
    apbBus.PWRITE  = wr;
    apbBus.PWDATA  = wdata;
    tick();
    apbBus.PENABLE = 1'b1;
    waits = 0;
    while ((apbBus.PREADY !== 1'b1) && (waits < 40)) begin
      waits++;
      tick();
    end
    if (waits >= 40) begin
      checks++;
      failures++;
      $error("[TB] FAIL pready_timeout observed=0 expected=1 addr=0x%04h", addr);
    end
    rdata  = apbBus.PRDATA;
    slverr = apbBus.PSLVERR;
    tick();
    apbBus.PSEL    = 1'b0;
    apbBus.PENABLE = 1'b0;
  endtask

  task automatic doReset();
    apbBus.PSEL    = 1'b0;
    apbBus.PENABLE = 1'b0;
    apbBus.PWRITE  = 1'b0;
    apbBus.PADDR   = '0;
    apbBus.PWDATA  = '0;
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    checkOutput("rst_pready", {31'b0, apbBus.PREADY}, 32'h0);
    checkOutput("rst_prdata", apbBus.PRDATA, 32'h0);
    checkOutput("rst_gpio_out", GPIO_OUT, 32'h0);
    checkOutput("rst_irq", {31'b0, IRQ}, 32'h0);

    // Basic reads with WAIT=0
    applyStimulus(16'h0014, 1'b0, 32'h0, rd, se, wt);
    checkOutput("count_after_reset", rd, 32'h0);
    checkOutput("count_wait0", wt, 32'd0);
    applyStimulus(16'h0000, 1'b0, 32'h0, rd, se, wt);
    checkOutput("id_read", rd, 32'hA5B0_0001);
    checkOutput("id_wait0", wt, 32'd0);
    checkOutput("id_slverr", {31'b0, se}, 32'h0);

    // WAIT=3 applies to the transfers after the CTRL write
    doReset();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0003, rd, se, wt);
    checkOutput("ctrl_wr_wait", wt, 32'd0);
    applyStimulus(16'h0008, 1'b1, 32'hDEAD_BEEF, rd, se, wt);
    checkOutput("scr0_wr_wait", wt, 32'd3);
    applyStimulus(16'h0008, 1'b0, 32'h0, rd, se, wt);
    checkOutput("scr0_rd_wait", wt, 32'd3);
    checkOutput("scr0_rd_data", rd, 32'hDEAD_BEEF);
    applyStimulus(16'h0014, 1'b0, 32'h0, rd, se, wt);
    checkOutput("count_3", rd, 32'd3);

    // Unmapped read with ERR_EN, then W1C clear
    doReset();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0100, rd, se, wt);
    applyStimulus(16'h0040, 1'b0, 32'h0, rd, se, wt);
    checkOutput("unmapped_slverr", {31'b0, se}, 32'h1);
    checkOutput("unmapped_rdata", rd, 32'h0);
    applyStimulus(16'h0010, 1'b0, 32'h0, rd, se, wt);
    checkOutput("status_unmapped", rd, 32'h1);
    applyStimulus(16'h0010, 1'b1, 32'h1, rd, se, wt);
    checkOutput("w1c_slverr", {31'b0, se}, 32'h0);
    applyStimulus(16'h0010, 1'b0, 32'h0, rd, se, wt);
    checkOutput("status_cleared", rd, 32'h0);
    applyStimulus(16'h0014, 1'b0, 32'h0, rd, se, wt);
    checkOutput("count_ok_only", rd, 32'd4);

    // Write to RO ID with ERR_EN=0 and IRQ_EN=1
    doReset();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0200, rd, se, wt);
    applyStimulus(16'h0000, 1'b1, 32'h0000_1234, rd, se, wt);
    checkOutput("ro_wr_slverr", {31'b0, se}, 32'h0);
    checkOutput("irq_before", {31'b0, IRQ}, 32'h0);
    tick();
    checkOutput("irq_after", {31'b0, IRQ}, 32'h1);
    applyStimulus(16'h0000, 1'b0, 32'h0, rd, se, wt);
    checkOutput("id_unchanged", rd, 32'hA5B0_0001);
    applyStimulus(16'h0010, 1'b0, 32'h0, rd, se, wt);
    checkOutput("status_ro_write", rd, 32'h4);

    // Abort after two wait cycles with WAIT=5
    doReset();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0205, rd, se, wt);
    applyStimulus(16'h0018, 1'b1, 32'h1234_5678, rd, se, wt);
    checkOutput("gpio_out_wait", wt, 32'd5);
    checkOutput("gpio_out_val", GPIO_OUT, 32'h1234_5678);
    apbBus.PSEL    = 1'b1;
    apbBus.PENABLE = 1'b0;
    apbBus.PADDR   = 16'h000C;
    apbBus.PWRITE  = 1'b1;
    apbBus.PWDATA  = 32'h0000_0055;
    tick();
    apbBus.PENABLE = 1'b1;
    checkOutput("abort_wait1", {31'b0, apbBus.PREADY}, 32'h0);
    tick();
    checkOutput("abort_wait2", {31'b0, apbBus.PREADY}, 32'h0);
    apbBus.PSEL    = 1'b0;
    apbBus.PENABLE = 1'b0;
    tick();
    checkOutput("abort_idle_pready", {31'b0, apbBus.PREADY}, 32'h0);
    applyStimulus(16'h000C, 1'b0, 32'h0, rd, se, wt);
    checkOutput("abort_scr1", rd, 32'h0);
    checkOutput("abort_rd_wait", wt, 32'd5);
    applyStimulus(16'h0010, 1'b0, 32'h0, rd, se, wt);
    checkOutput("abort_status", rd, 32'h2);
    checkOutput("abort_irq", {31'b0, IRQ}, 32'h1);

    // Asynchronous reset in the middle of a wait phase
    apbBus.PSEL    = 1'b1;
    apbBus.PENABLE = 1'b0;
    apbBus.PADDR   = 16'h0018;
    apbBus.PWRITE  = 1'b0;
    tick();
    apbBus.PENABLE = 1'b1;
    tick();
    #2;
    HRESETn = 1'b0;
    #1;
    checkOutput("midrst_pready", {31'b0, apbBus.PREADY}, 32'h0);
    checkOutput("midrst_prdata", apbBus.PRDATA, 32'h0);
    checkOutput("midrst_pslverr", {31'b0, apbBus.PSLVERR}, 32'h0);
    checkOutput("midrst_gpio_out", GPIO_OUT, 32'h0);
    checkOutput("midrst_irq", {31'b0, IRQ}, 32'h0);

    // Gated PCLKEN: WAIT=2 read of GPIO_IN counts enabled edges only
    doReset();
    applyStimulus(16'h0004, 1'b1, 32'h0000_0002, rd, se, wt);
    GPIO_IN = 32'hCAFE_0001;
    tick();
    tick();
    gateMode = 1'b1;
    tick();
    applyStimulus(16'h001C, 1'b0, 32'h0, rd, se, wt);
    checkOutput("gated_wait", wt, 32'd2);
    checkOutput("gated_gpio_in", rd, 32'hCAFE_0001);
    checkOutput("gated_slverr", {31'b0, se}, 32'h0);
    gateMode = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
